// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 serial transmitter with a small byte FIFO on the CPU side.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_DIV_NUMBER = 10,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_to_uart_buf,
    input  logic       cpu_write,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       write_int,
    output logic       uart_out
);

    localparam int                  c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam logic [7:0]          c_DIV_MAX = 8'(CLK_DIV_NUMBER - 1);
    localparam logic [c_ADDR_W:0]   c_FULL    = (c_ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [7:0]          r_div;
    logic [7:0]          w_div_nx;
    logic [2:0]          r_bitcnt;
    logic [2:0]          w_bitcnt_nx;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nx;
    logic                r_uart_out;
    logic                w_uart_nx;
    logic                r_write_int;
    logic                w_write_int_nx;
    logic                r_overflow;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_ADDR_W:0]   r_count;

    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_div_wrap;
    logic [7:0]          w_head;

    // Full is judged on the registered count, so a pop on the same edge
    // never lets a push through.
    assign tx_full     = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = cpu_write && !tx_full;
    assign w_head      = r_mem[r_rptr];
    assign w_div_wrap  = (r_div == c_DIV_MAX);

    assign tx_busy     = (r_state != ST_IDLE) || !w_empty;
    assign tx_overflow = r_overflow;
    assign write_int   = r_write_int;
    assign uart_out    = r_uart_out;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= cpu_to_uart_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (cpu_write && tx_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_uart_out  <= 1'b1;
            r_write_int <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_div       <= w_div_nx;
            r_bitcnt    <= w_bitcnt_nx;
            r_shift     <= w_shift_nx;
            r_uart_out  <= w_uart_nx;
            r_write_int <= w_write_int_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_div_nx       = w_div_wrap ? 8'd0 : r_div + 8'd1;
        w_bitcnt_nx    = r_bitcnt;
        w_shift_nx     = r_shift;
        w_uart_nx      = r_uart_out;
        w_write_int_nx = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_div_nx  = r_div;
                w_uart_nx = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_uart_nx  = 1'b0;
                    w_div_nx   = 8'd0;
                    w_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (w_div_wrap) begin
                    w_uart_nx   = r_shift[0];
                    w_bitcnt_nx = 3'd0;
                    w_state_nx  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_div_wrap) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bitcnt != 3'd7) begin
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                        w_uart_nx   = r_shift[1];
                    end else begin
                        w_uart_nx  = 1'b1;
                        w_state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_div_wrap) begin
                    w_write_int_nx = 1'b1;
                    // Chain straight into the next frame when data is waiting.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_uart_nx  = 1'b0;
                        w_state_nx = ST_START;
                    end else begin
                        w_uart_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
